// File: rtl/input_vec_loader.sv
// Double-banked vector loader: the host fills one bank element by element while the model drains the other.
// Vectors leave in the order they arrived. Puts that arrive while both banks hold unread vectors are dropped.
module input_vec_loader #(
  parameter int DATA_W  = 8,
  parameter int VEC_LEN = 16
) (
  input  logic                           clk,
  input  logic                           sys_rst_n,
  input  logic [DATA_W-1:0]              byte_in,
  input  logic                           pc_data_put,
  input  logic                           clear,
  output logic                           all_in_ready,
  output logic [DATA_W-1:0]              m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_last,
  output logic [$clog2(VEC_LEN+1)-1:0]   fill_cnt,
  output logic                           overflow
);

  localparam int IDX_W = $clog2(VEC_LEN);
  localparam int CNT_W = $clog2(VEC_LEN+1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN-1);

  logic [DATA_W-1:0] bank_q [2][VEC_LEN];
  logic [DATA_W-1:0] bank_d [2][VEC_LEN];
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic              overflow_q, overflow_d;
  logic              handshake;

  assign handshake = full_q[rd_bank_q] & m_ready;

  // Fill and drain always target different banks when both are active, so the
  // two full-flag updates below never touch the same bit in one cycle.
  always_comb begin
    bank_d     = bank_q;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    overflow_d = overflow_q;

    if (clear) begin
      wr_idx_d   = '0;
      overflow_d = 1'b0;
    end else if (pc_data_put) begin
      if (full_q[wr_bank_q]) begin
        overflow_d = 1'b1;
      end else begin
        bank_d[wr_bank_q][wr_idx_q] = byte_in;
        if (wr_idx_q == LAST_IDX) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
          wr_idx_d          = '0;
        end else begin
          wr_idx_d = wr_idx_q + IDX_W'(1);
        end
      end
    end

    if (handshake) begin
      if (rd_idx_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_idx_d          = '0;
      end else begin
        rd_idx_d = rd_idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      full_q     <= 2'b00;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Bank contents are qualified by the full flags, so they need no reset.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  assign m_valid      = full_q[rd_bank_q];
  assign m_data       = bank_q[rd_bank_q][rd_idx_q];
  assign m_last       = m_valid & (rd_idx_q == LAST_IDX);
  assign all_in_ready = full_q[0] | full_q[1];
  assign fill_cnt     = CNT_W'(wr_idx_q);
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_input_vec_loader.sv
// Self-checking bench for input_vec_loader (VEC_LEN=4): a vector table plus hand-written corner sequences,
// all cross-checked every cycle against a queue-based scoreboard of accepted vectors.
module tb_input_vec_loader;

  localparam int DATA_W  = 8;
  localparam int VEC_LEN = 4;
  localparam int CNT_W   = $clog2(VEC_LEN+1);

  logic              clk;
  logic              sys_rst_n;
  logic [DATA_W-1:0] byte_in;
  logic              pc_data_put;
  logic              clear;
  logic              all_in_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [CNT_W-1:0]  fill_cnt;
  logic              overflow;

  input_vec_loader #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN)) dut (
    .clk          (clk),
    .sys_rst_n    (sys_rst_n),
    .byte_in      (byte_in),
    .pc_data_put  (pc_data_put),
    .clear        (clear),
    .all_in_ready (all_in_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .fill_cnt     (fill_cnt),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared;
  int mismatched;

  // Scoreboard: partialQ holds accepted bytes of the vector being filled,
  // drainQ holds complete vectors awaiting the model, in arrival order.
  logic [DATA_W-1:0] partialQ [$];
  logic [DATA_W-1:0] drainQ [$];
  int                fullVecs;
  int                drainPos;
  logic              expOverflow;

  typedef struct {
    logic              put;
    logic [DATA_W-1:0] data;
    logic              clr;
    logic              rdy;
    int                expFill;
    logic              expAir;
    logic              expValid;
    logic [DATA_W-1:0] expData;
    logic              expLast;
  } vec_t;

  vec_t tbl [8];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    partialQ.delete();
    drainQ.delete();
    fullVecs    = 0;
    drainPos    = 0;
    expOverflow = 1'b0;
  endtask

  // Checks the pre-edge outputs against the scoreboard, then advances the
  // scoreboard by what the coming edge should do with the driven inputs.
  task automatic checkOutput();
    int vecDone;
    int vecWritten;
    vecDone    = 0;
    vecWritten = 0;
    cmp("m_valid", m_valid, fullVecs > 0);
    cmp("all_in_ready", all_in_ready, fullVecs > 0);
    cmp("fill_cnt", fill_cnt, partialQ.size());
    cmp("overflow", overflow, expOverflow);
    if (fullVecs > 0) begin
      cmp("m_data", m_data, drainQ[0]);
      cmp("m_last", m_last, drainPos == VEC_LEN-1);
    end else begin
      cmp("m_last_idle", m_last, 1'b0);
    end

    if (fullVecs > 0 && m_ready) begin
      void'(drainQ.pop_front());
      drainPos++;
      if (drainPos == VEC_LEN) begin
        drainPos = 0;
        vecDone  = 1;
      end
    end

    if (clear) begin
      partialQ.delete();
      expOverflow = 1'b0;
    end else if (pc_data_put) begin
      if (fullVecs < 2) begin
        partialQ.push_back(byte_in);
        if (partialQ.size() == VEC_LEN) begin
          foreach (partialQ[i]) drainQ.push_back(partialQ[i]);
          partialQ.delete();
          vecWritten = 1;
        end
      end else begin
        expOverflow = 1'b1;
      end
    end
    fullVecs = fullVecs - vecDone + vecWritten;
  endtask

  // One clock cycle: drive on the falling edge, check just after, return 1ns past the rising edge.
  task automatic applyStimulus(input logic put, input logic [DATA_W-1:0] b,
                               input logic clr, input logic rdy);
    @(negedge clk);
    pc_data_put = put;
    byte_in     = b;
    clear       = clr;
    m_ready     = rdy;
    #1;
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    sys_rst_n   = 1'b0;
    pc_data_put = 1'b0;
    byte_in     = '0;
    clear       = 1'b0;
    m_ready     = 1'b0;
    modelReset();

    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 3, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b0, 0, 1'b1, 1'b1, 8'h11, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b1, 8'h22, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b1, 8'h33, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b1, 8'h44, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 8'h00, 1'b0};

    #12;
    cmp("rst_m_valid", m_valid, 1'b0);
    cmp("rst_all_in_ready", all_in_ready, 1'b0);
    cmp("rst_fill_cnt", fill_cnt, 0);
    cmp("rst_overflow", overflow, 1'b0);
    cmp("rst_m_last", m_last, 1'b0);
    @(negedge clk);
    sys_rst_n = 1'b1;

    $display("[TB] basic fill and drain table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].put, tbl[i].data, tbl[i].clr, tbl[i].rdy);
      cmp($sformatf("tbl%0d_fill_cnt", i), fill_cnt, tbl[i].expFill);
      cmp($sformatf("tbl%0d_all_in_ready", i), all_in_ready, tbl[i].expAir);
      cmp($sformatf("tbl%0d_m_valid", i), m_valid, tbl[i].expValid);
      cmp($sformatf("tbl%0d_m_last", i), m_last, tbl[i].expLast);
      if (tbl[i].expValid) cmp($sformatf("tbl%0d_m_data", i), m_data, tbl[i].expData);
    end

    $display("[TB] overflow with both banks full");
    for (int i = 1; i <= 12; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    cmp("ovf_set", overflow, 1'b1);
    cmp("ovf_m_data_first", m_data, 8'h01);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    cmp("ovf_drained_valid", m_valid, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    cmp("ovf_cleared", overflow, 1'b0);

    $display("[TB] put into bank freed by last read is dropped");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h68, 1'b0, 1'b1);
    cmp("freed_put_overflow", overflow, 1'b1);
    cmp("freed_put_fill_cnt", fill_cnt, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] continuous stream");
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    cmp("stream_no_overflow", overflow, 1'b0);

    $display("[TB] clear discards partial vector");
    applyStimulus(1'b1, 8'h91, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h92, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    cmp("clear_fill_cnt", fill_cnt, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    cmp("clear_first_elem", m_data, 8'hA0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    cmp("clear_put_fill_cnt", fill_cnt, 0);
    cmp("clear_put_overflow", overflow, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
    cmp("clear_put_first_elem", m_data, 8'hB0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    $display("[TB] asynchronous reset mid-drain");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hD0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hD1, 1'b0, 1'b1);
    cmp("pre_rst_m_valid", m_valid, 1'b1);
    cmp("pre_rst_fill_cnt", fill_cnt, 2);
    cmp("pre_rst_m_data", m_data, 8'hC2);
    pc_data_put = 1'b0;
    m_ready     = 1'b0;
    #1;
    sys_rst_n = 1'b0;
    #1;
    cmp("async_rst_m_valid", m_valid, 1'b0);
    cmp("async_rst_all_in_ready", all_in_ready, 1'b0);
    cmp("async_rst_fill_cnt", fill_cnt, 0);
    cmp("async_rst_m_last", m_last, 1'b0);
    modelReset();
    @(negedge clk);
    sys_rst_n = 1'b1;
    applyStimulus(1'b1, 8'hE0, 1'b0, 1'b0);
    cmp("post_rst_first_put", fill_cnt, 1);
    for (int i = 1; i < 4; i++) applyStimulus(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/input_vec_loader.md
INPUT_VEC_LOADER -- requirements
Module: input_vec_loader

Interface
REQ-001 Parameter DATA_W, default 8, width of one host byte/element.
REQ-002 Parameter VEC_LEN, default 16, elements per inference vector; legal range 2..256.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 byte_in  input  DATA_W  element from host bridge.
REQ-006 pc_data_put  input  1  one-cycle strobe: byte_in valid this cycle.
REQ-007 clear  input  1  synchronous discard of partially filled vector and overflow flag.
REQ-008 all_in_ready  output  1  at least one complete vector buffered.
REQ-009 m_data  output  DATA_W  element to model.
REQ-010 m_valid  output  1  m_data valid.
REQ-011 m_ready  input  1  model accepts element.
REQ-012 m_last  output  1  m_data is final element of its vector.
REQ-013 fill_cnt  output  clog2(VEC_LEN+1)  elements written into current fill bank.
REQ-014 overflow  output  1  sticky: a put was dropped.

Function
REQ-015 Storage: two register banks (0,1) of VEC_LEN x DATA_W; per-bank full flag; write pointer wr_bank/wr_idx; read pointer rd_bank/rd_idx.
REQ-016 Per-bank states: FILLING (bank==wr_bank, not full), FULL (full set, awaiting drain), DRAINING (bank==rd_bank, full, rd_idx>0); FILLING->FULL on last write, FULL/DRAINING->FILLING-eligible on last read handshake.
REQ-017 Put with bank[wr_bank] not full: store byte_in at wr_idx, wr_idx+1; at wr_idx==VEC_LEN-1 instead set full[wr_bank], toggle wr_bank, wr_idx<=0.
REQ-018 Put with bank[wr_bank] full (both banks full): byte dropped, no pointer change, overflow<=1.
REQ-019 m_valid = full[rd_bank]; m_data = bank[rd_bank][rd_idx]; m_last = m_valid and rd_idx==VEC_LEN-1; all combinational from registers, zero latency.
REQ-020 Handshake m_valid&m_ready: rd_idx+1; on m_last clear full[rd_bank], toggle rd_bank, rd_idx<=0.
REQ-021 m_data/m_last SHALL hold stable while m_valid & !m_ready.
REQ-022 Put and handshake in same cycle always both execute (fill and drain banks are always distinct when both active).
REQ-023 Last-write and last-read in same cycle: bank just drained becomes writable next cycle; all_in_ready remains 1 (other bank now full).
REQ-024 Put landing in a bank the same cycle it is freed by last read is dropped and flags overflow (full evaluated pre-edge).
REQ-025 clear: wr_idx<=0, overflow<=0; full flags, read side untouched; clear with put same cycle -> clear wins, byte discarded, overflow unchanged (0).
REQ-026 all_in_ready = full[0] | full[1]; fill_cnt = wr_idx.
REQ-027 First vector written goes to bank 0; vectors leave in arrival order.

Reset
REQ-028 sys_rst_n low: wr_bank=rd_bank=0, wr_idx=rd_idx=0, full=00, overflow=0 immediately, asynchronously; outputs m_valid=0, m_last=0, all_in_ready=0, fill_cnt=0.
REQ-029 Reset mid-fill or mid-drain discards all buffered data; bank contents need not be cleared.
REQ-030 Deassertion SHALL be synchronised externally; first put accepted on first edge after release.

Verification (VEC_LEN=4)
REQ-031 Puts 0x11,0x22,0x33,0x44, m_ready=0 -> fill_cnt 1,2,3,0; all_in_ready=1 and m_valid=1 cycle after 4th put, m_data=0x11.
REQ-032 Then m_ready=1 four cycles -> m_data 0x11,0x22,0x33,0x44, m_last only on 0x44; m_valid=0, all_in_ready=0 after.
REQ-033 12 puts with m_ready=0 -> puts 9-12 dropped, overflow=1, banks hold puts 1-4 then 5-8 drained in that order; clear -> overflow=0.
REQ-034 Continuous put each cycle with m_ready=1 -> no drops, output sequence equals input sequence, overflow stays 0.
REQ-035 Two puts, clear, four puts 0xA0..0xA3 -> drained vector is 0xA0..0xA3; clear+put same cycle -> byte absent.
REQ-036 Assert sys_rst_n=0 mid-drain (rd_idx=2) -> m_valid, all_in_ready, fill_cnt drop to 0 without clock edge.
